// File: rtl/dmem_rw_if.sv
// Request/response channel between the load/store stage and the data memory.
// The master issues sized accesses; the slave answers one cycle later.
interface dmem_rw_if #(
    parameter int addr_width = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [addr_width-1:0] req_addr;
    logic [2:0]            req_funct3;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_rw.sv
// Byte-addressable little-endian data memory with sized loads/stores and a
// single registered response slot; faulting accesses never touch the array.
module dmem_rw #(
    parameter int    addr_width = 32,
    parameter int    data_width = 32,
    parameter int    mem_depth  = 256,
    parameter string init_file  = ""
) (
    input  logic     clk,
    input  logic     rst_n,
    dmem_rw_if.slave bus
);
    localparam int idx_width = $clog2(mem_depth);
    localparam logic [addr_width:0] depth_c = (addr_width + 1)'(mem_depth);

    logic [7:0] mem_r [mem_depth];

    logic                  accept_s;
    logic [2:0]            size_s;
    logic                  illegal_s;
    logic                  misalign_s;
    logic                  range_err_s;
    logic                  err_s;
    logic [addr_width:0]   end_addr_s;
    logic [idx_width-1:0]  idx_s;
    logic [7:0]            rd_byte_s [4];
    logic [data_width-1:0] load_data_s;
    logic [31:0]           rdata_next_s;

    logic                  resp_valid_r;
    logic [31:0]           resp_rdata_r;
    logic                  resp_err_r;

    assign bus.req_ready  = !resp_valid_r || bus.resp_ready;
    assign accept_s       = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;

    // Size decode, alignment and full-width range check of the request.
    always_comb begin
        size_s    = 3'd1;
        illegal_s = 1'b0;
        case (bus.req_funct3)
            3'b000:  size_s = 3'd1;
            3'b001:  size_s = 3'd2;
            3'b010:  size_s = 3'd4;
            3'b100: begin
                size_s    = 3'd1;
                illegal_s = bus.req_we;
            end
            3'b101: begin
                size_s    = 3'd2;
                illegal_s = bus.req_we;
            end
            default: illegal_s = 1'b1;
        endcase

        case (size_s)
            3'd2:    misalign_s = bus.req_addr[0];
            3'd4:    misalign_s = (bus.req_addr[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase

        end_addr_s  = {1'b0, bus.req_addr} + (addr_width + 1)'(size_s)
                      - (addr_width + 1)'(1);
        range_err_s = (end_addr_s >= depth_c);
        err_s       = illegal_s || misalign_s || range_err_s;
    end

    // Load path: gather four bytes (index wraps, only used when in range) and extend.
    always_comb begin
        idx_s = bus.req_addr[idx_width-1:0];
        for (int k = 0; k < 4; k++) begin
            rd_byte_s[k] = mem_r[idx_s + idx_width'(k)];
        end

        case (bus.req_funct3)
            3'b000:  load_data_s = {{24{rd_byte_s[0][7]}}, rd_byte_s[0]};
            3'b001:  load_data_s = {{16{rd_byte_s[1][7]}}, rd_byte_s[1], rd_byte_s[0]};
            3'b010:  load_data_s = {rd_byte_s[3], rd_byte_s[2], rd_byte_s[1], rd_byte_s[0]};
            3'b100:  load_data_s = {24'd0, rd_byte_s[0]};
            3'b101:  load_data_s = {16'd0, rd_byte_s[1], rd_byte_s[0]};
            default: load_data_s = 32'd0;
        endcase

        if (err_s || bus.req_we) begin
            rdata_next_s = 32'd0;
        end else begin
            rdata_next_s = load_data_s;
        end
    end

    // Response slot: replaced on every accept, cleared once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else if (accept_s) begin
            resp_valid_r <= 1'b1;
            resp_rdata_r <= rdata_next_s;
            resp_err_r   <= err_s;
        end else if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
        end
    end

    // Store commit; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept_s && bus.req_we && !err_s) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < size_s) begin
                    mem_r[idx_s + idx_width'(k)] <= bus.req_wdata[8*k +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_rw.sv
// Directed test of dmem_rw: sized loads/stores, faults, back-pressure,
// back-to-back throughput and asynchronous reset.
module tb_dmem_rw;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    dmem_rw_if #(.addr_width(32)) bus ();

    dmem_rw #(
        .addr_width(32),
        .data_width(32),
        .mem_depth (256),
        .init_file ("")
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One accepted access followed by its response check one edge later.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        bus.req_wdata  = wd;
        chk({tag, "_rdy"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk({tag, "_vld"}, {31'd0, bus.resp_valid}, 32'd1);
        chk({tag, "_data"}, bus.resp_rdata, exp_rd);
        chk({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, exp_err});
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_funct3 = 3'b000;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_data", bus.resp_rdata, 32'd0);
        chk("rst_err", {31'd0, bus.resp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", {31'd0, bus.req_ready}, 32'd1);

        // Word store and sized loads
        access("sw10",  1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0);
        access("lw10",  1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0);
        access("lbu10", 1'b0, 32'h10, 3'b100, 32'h0,        32'h000000EF, 1'b0);
        access("lb13",  1'b0, 32'h13, 3'b000, 32'h0,        32'hFFFFFFDE, 1'b0);

        // Half store over a word
        access("sw20",  1'b1, 32'h20, 3'b010, 32'h11223344, 32'h0,        1'b0);
        access("sh20",  1'b1, 32'h20, 3'b001, 32'h00008001, 32'h0,        1'b0);
        access("lw20",  1'b0, 32'h20, 3'b010, 32'h0,        32'h11228001, 1'b0);
        access("lh20",  1'b0, 32'h20, 3'b001, 32'h0,        32'hFFFF8001, 1'b0);
        access("lhu20", 1'b0, 32'h20, 3'b101, 32'h0,        32'h00008001, 1'b0);

        // Misaligned / out-of-range faults leave memory untouched
        access("lw22",  1'b0, 32'h22,       3'b010, 32'h0,        32'h0, 1'b1);
        access("sh21",  1'b1, 32'h21,       3'b001, 32'h0000AAAA, 32'h0, 1'b1);
        access("lhff",  1'b0, 32'hFF,       3'b001, 32'h0,        32'h0, 1'b1);
        access("sw100", 1'b1, 32'h100,      3'b010, 32'h55555555, 32'h0, 1'b1);
        access("swhi",  1'b1, 32'h80000010, 3'b010, 32'h0,        32'h0, 1'b1);
        access("lwhi",  1'b0, 32'h80000010, 3'b010, 32'h0,        32'h0, 1'b1);
        access("lw10b", 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);
        access("lw20b", 1'b0, 32'h20, 3'b010, 32'h0, 32'h11228001, 1'b0);

        // Illegal size codes
        access("f3_011", 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
        access("sbu",    1'b1, 32'h10, 3'b100, 32'h0, 32'h0, 1'b1);
        access("lw10c",  1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);

        // Top-of-memory boundary
        access("swfc",  1'b1, 32'hFC, 3'b010, 32'h01020304, 32'h0,        1'b0);
        access("lwfc",  1'b0, 32'hFC, 3'b010, 32'h0,        32'h01020304, 1'b0);
        access("shfe",  1'b1, 32'hFE, 3'b001, 32'h0000C35A, 32'h0,        1'b0);
        access("lhfe",  1'b0, 32'hFE, 3'b001, 32'h0,        32'hFFFFC35A, 1'b0);
        access("lbuff", 1'b0, 32'hFF, 3'b100, 32'h0,        32'h000000C3, 1'b0);
        access("lwfcb", 1'b0, 32'hFC, 3'b010, 32'h0,        32'hC35A0304, 1'b0);

        // Consumed response with no new accept drops valid
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("idle_vld", {31'd0, bus.resp_valid}, 32'd0);

        // Back-pressure: response held for three cycles, new request stalled
        access("bp_lw", 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b1;
            bus.req_addr   = 32'h10;
            bus.req_funct3 = 3'b010;
            bus.req_wdata  = 32'h12345678;
            chk("bp_rdy", {31'd0, bus.req_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk("bp_vld", {31'd0, bus.resp_valid}, 32'd1);
            chk("bp_data", bus.resp_rdata, 32'hDEADBEEF);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        #1;
        chk("bp_rdy1", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("bp_sw_vld", {31'd0, bus.resp_valid}, 32'd1);
        chk("bp_sw_data", bus.resp_rdata, 32'h0);
        access("bp_lw2", 1'b0, 32'h10, 3'b010, 32'h0, 32'h12345678, 1'b0);

        // Eight back-to-back accesses, read-after-write included
        access("b2b0", 1'b1, 32'h40, 3'b000, 32'h00000001, 32'h0,        1'b0);
        access("b2b1", 1'b1, 32'h41, 3'b000, 32'h00000002, 32'h0,        1'b0);
        access("b2b2", 1'b1, 32'h42, 3'b000, 32'h00000003, 32'h0,        1'b0);
        access("b2b3", 1'b1, 32'h43, 3'b000, 32'h00000084, 32'h0,        1'b0);
        access("b2b4", 1'b0, 32'h40, 3'b010, 32'h0,        32'h84030201, 1'b0);
        access("b2b5", 1'b0, 32'h41, 3'b100, 32'h0,        32'h00000002, 1'b0);
        access("b2b6", 1'b0, 32'h43, 3'b000, 32'h0,        32'hFFFFFF84, 1'b0);
        access("b2b7", 1'b0, 32'h42, 3'b101, 32'h0,        32'h00008403, 1'b0);

        // Asynchronous reset while a response is pending
        access("pre_rst", 1'b0, 32'h10, 3'b010, 32'h0, 32'h12345678, 1'b0);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h20;
        bus.req_funct3 = 3'b010;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", {31'd0, bus.resp_valid}, 32'd0);
        chk("arst_data", bus.resp_rdata, 32'h0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access("post_rst", 1'b0, 32'h20, 3'b010, 32'h0, 32'h11228001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_rw.md
Name: dmem_rw

Overview:
- Byte-addressable, little-endian data memory serving the CPU's load/store stage.
- It is the read/write counterpart of the combinational instruction ROM. It accepts sized stores (SB/SH/SW) and sized loads (LB/LH/LW/LBU/LHU) through a valid/ready request channel.
- It returns a registered response one cycle later on a valid/ready response channel.
- Misaligned, out-of-range and illegal-size accesses are flagged and never modify memory.

Parameters:
- addr_width, 32, width of req_addr.
- data_width, 32, width of req_wdata and resp_rdata; fixed at 32 for this block.
- mem_depth, 256, number of byte locations; must be a power of two, max 2^addr_width.
- init_file, "", binary image loaded with $readmemb at time 0 when non-empty; otherwise contents are undefined until written.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  addr_width  byte address.
- req_funct3  in  3  RISC-V size/sign code.
- req_wdata  in  32  store data; low bytes are used for SB/SH.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response this cycle.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  access faulted.

Behaviour:
- Reset (async assert, sync release): resp_valid=0, resp_rdata=0, resp_err=0. Memory array is not reset. req_ready=1 once out of reset.
- req_ready = !resp_valid || resp_ready. This is combinational and gives single-entry pipeline throughput of one access per cycle.
- Accept: a request is accepted on a rising edge with req_valid && req_ready. The response appears on the next edge (latency 1).
- Response hold: resp_valid stays 1 and resp_rdata/resp_err stay stable until a cycle with resp_ready=1.
  - resp_ready=1 and a new accept in the same cycle: the response is replaced by the new one and resp_valid stays 1.
  - resp_ready=1 and no accept: resp_valid goes to 0.
- funct3 map:
  - 000: LB/SB.
  - 001: LH/SH.
  - 010: LW/SW.
  - 100: LBU (load only).
  - 101: LHU (load only).
  - Any other code, or 100/101 with req_we=1, is illegal and sets err.
- Alignment: a half access requires addr[0]=0; a word access requires addr[1:0]=0. A misaligned access sets err.
- Range: addr + size - 1 >= mem_depth sets err. Use full-width compare; upper address bits are not ignored.
- Error response: resp_err=1, resp_rdata=0, no memory write.
- Store commit: on the accept edge, the selected bytes are written at mem[addr..addr+n-1], little-endian (wdata[7:0] goes to the lowest address). Other bytes are untouched. resp_rdata=0.
- Load data: read from memory state before any write in the same edge; this cannot collide because only one access is accepted per cycle.
  - LB/LH: sign-extend to 32 bits.
  - LBU/LHU: zero-extend to 32 bits.
  - LW: no extension.
- Read-after-write: a load accepted the cycle after a store to the same bytes returns the stored data.
- Reset mid-operation: a pending response is dropped. A store accepted on the edge coincident with reset assertion may or may not commit; verification must not depend on this.
- Memory is implemented as reg [7:0] mem[mem_depth-1:0]; no hidden buffering beyond the response register.

Test Plan:
- SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> store response rdata=0 err=0, then LW returns 0xDEADBEEF. LBU 0x10 returns 0xEF; LB 0x13 returns 0xFFFFFFDE.
- SH 0x20 wdata 0x00008001 over a prior SW 0x20 of 0x11223344 -> LW 0x20 returns 0x11228001. LH 0x20 returns 0xFFFF8001; LHU 0x20 returns 0x00008001.
- LW 0x22, SH 0x21, LH 0x0FF (depth 256), SW 0x100 -> each gives err=1 rdata=0. A following LW at the original locations shows memory unchanged.
- funct3=011 load and funct3=100 store -> err=1, no write.
- Back-pressure: hold resp_ready=0 for 3 cycles after an LW of 0x10 -> resp_valid and resp_rdata stay stable and req_ready=0. New requests are not accepted until resp_ready=1.
- Back-to-back: 8 consecutive requests with resp_ready=1 -> 8 responses on 8 consecutive cycles, in order. Assert rst_n=0 mid-stream -> resp_valid=0 immediately (asynchronous).
